pipe_issue: RTL and testbench

- Front-end stage that feeds the 4-stage arithmetic pipeline.
- Buffers packed 24-bit instruction words in a small FIFO, decodes them into rs1/rs2/rd/func/addr fields, and issues one per clk1 cycle.
- The downstream pipeline has no forwarding: regbank is written one full cycle after execute. This block therefore holds back any instruction whose source register matches the destination of a still-in-flight instruction.

---
 rtl/pipe_defs.sv | 48 ++++
 rtl/pipe_ififo.sv | 51 +++++
 rtl/pipe_issue.sv | 109 ++++++++++
 tb/tb_pipe_issue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared field layout and func codes for the pipeline front end
package pipe_defs;

  localparam int FUNC_W  = 4;
  localparam int REG_W   = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  localparam int FUNC_LSB = 20;
  localparam int RS1_LSB  = 16;
  localparam int RS2_LSB  = 12;
  localparam int RD_LSB   = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [FUNC_W-1:0] {
    F_ADD   = 4'd0,
    F_SUB   = 4'd1,
    F_MUL   = 4'd2,
    F_AND   = 4'd3,
    F_OR    = 4'd4,
    F_XOR   = 4'd5,
    F_PASSA = 4'd6,
    F_PASSB = 4'd7,
    F_NEGA  = 4'd8,
    F_NEGB  = 4'd9,
    F_SRA   = 4'd10,
    F_SLA   = 4'd11
  } func_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.func = w[FUNC_LSB +: FUNC_W];
    d.rs1  = w[RS1_LSB  +: REG_W];
    d.rs2  = w[RS2_LSB  +: REG_W];
    d.rd   = w[RD_LSB   +: REG_W];
    d.addr = w[ADDR_LSB +: ADDR_W];
    return d;
  endfunction

endpackage

// File: rtl/pipe_ififo.sv
// rtl/pipe_ififo.sv - DEPTH x W synchronous instruction FIFO, refuses pushes while full
module pipe_ififo #(
  parameter int DEPTH = 8,
  parameter int W     = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk1) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// rtl/pipe_issue.sv - buffers, decodes and issues instructions, stalling on RAW hazards
module pipe_issue
  import pipe_defs::*;
#(
  parameter int DEPTH   = 8,
  parameter int HAZ_WIN = 2
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     hold,
  output logic [REG_W-1:0]         rs1,
  output logic [REG_W-1:0]         rs2,
  output logic [REG_W-1:0]         rd,
  output logic [FUNC_W-1:0]        func,
  output logic [ADDR_W-1:0]        addr,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              issue_cnt,
  output logic [15:0]              stall_cnt
);

  logic [INSTR_W-1:0] head_word;
  logic               full;
  logic               empty;
  logic               do_issue;
  logic               do_stall;
  logic               hazard;
  instr_t             head;

  logic [HAZ_WIN-1:0] sb_valid;
  logic [REG_W-1:0]   sb_rd [HAZ_WIN];

  assign in_ready = !full;

  pipe_ififo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk1  (clk1),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_instr),
    .pop   (do_issue),
    .rdata (head_word),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign head = decode(head_word);

  // Both sources are checked regardless of func; single-operand ops stall conservatively.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_valid[i] && ((sb_rd[i] == head.rs1) || (sb_rd[i] == head.rs2)))
        hazard = 1'b1;
    end
  end

  assign do_issue = !hold && !empty && !hazard;
  assign do_stall = !hold && !empty && hazard;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= '0;
      addr        <= '0;
      issue_valid <= 1'b0;
    end else if (!hold) begin
      issue_valid <= do_issue;
      if (do_issue) begin
        rs1  <= head.rs1;
        rs2  <= head.rs2;
        rd   <= head.rd;
        func <= head.func;
        addr <= head.addr;
      end
    end
  end

  // Entry 0 is the slot just issued; a stall or idle cycle inserts a bubble.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      for (int i = 0; i < HAZ_WIN; i++) sb_rd[i] <= '0;
    end else if (!hold) begin
      sb_valid[0] <= do_issue;
      sb_rd[0]    <= head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (do_issue && (issue_cnt != 16'hFFFF)) issue_cnt <= issue_cnt + 16'd1;
      if (do_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_issue.sv
// tb/tb_pipe_issue.sv - directed scoreboard bench for pipe_issue
module tb_pipe_issue;

  logic        clk1;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic        hold;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid;
  logic [3:0]  fifo_level;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;
  logic [23:0] exp_q [$];
  int          iss_cyc [$];
  logic [23:0] snap;
  logic [15:0] snap_ic, snap_sc;

  pipe_issue #(.DEPTH(8), .HAZ_WIN(2)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .hold        (hold),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .issue_valid (issue_valid),
    .fifo_level  (fifo_level),
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge; any fresh issue is popped from the scoreboard and compared.
  task automatic tick();
    logic        h;
    logic [23:0] got;
    logic [23:0] e;
    h = hold;
    @(posedge clk1);
    #1;
    cyc++;
    if (issue_valid && !h && rst_n) begin
      got = {func, rs1, rs2, rd, addr};
      if (exp_q.size() == 0) begin
        chk("issue_extra", {8'h0, got}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("issue_fields", {8'h0, got}, {8'h0, e});
        iss_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic push(input logic [23:0] w);
    in_valid = 1'b1;
    in_instr = w;
    if (in_ready) begin
      exp_q.push_back(w);
      acc++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    hold     = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_issue_valid", {31'h0, issue_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_fifo_level", {28'h0, fifo_level}, 32'h0);
    chk("rst_issue_cnt", {16'h0, issue_cnt}, 32'h0);
    chk("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("rst_fields", {8'h0, func, rs1, rs2, rd, addr}, 32'h0);

    // Independent pair
    iss_cyc.delete();
    push(24'h035A7D);
    push(24'h230C7E);
    tick();
    tick();
    tick();
    chk("pair_issues", iss_cyc.size(), 2);
    chk("pair_gap", iss_cyc[1] - iss_cyc[0], 1);
    chk("pair_rd", {28'h0, rd}, 32'hC);
    chk("pair_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("pair_issue_cnt", {16'h0, issue_cnt}, 32'h2);

    // RAW stall: sub depends on add's rd
    iss_cyc.delete();
    push(24'h035A7D);
    push(24'h1A5E80);
    for (int i = 0; i < 6; i++) tick();
    chk("raw_issues", iss_cyc.size(), 2);
    chk("raw_gap", iss_cyc[1] - iss_cyc[0], 3);
    chk("raw_stall_cnt", {16'h0, stall_cnt}, 32'h2);
    chk("raw_rs1", {28'h0, rs1}, 32'hA);
    chk("raw_rd", {28'h0, rd}, 32'hE);
    chk("raw_addr", {24'h0, addr}, 32'h80);
    chk("raw_issue_cnt", {16'h0, issue_cnt}, 32'h4);

    // Full and backpressure under hold
    hold = 1'b1;
    acc  = 0;
    for (int i = 0; i < 9; i++) push({4'h0, 4'h1, 4'h2, 4'(3 + i), 8'(i)});
    chk("full_accepted", acc, 8);
    chk("full_level", {28'h0, fifo_level}, 32'h8);
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    iss_cyc.delete();
    hold = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("drain_issues", iss_cyc.size(), 8);
    chk("drain_span", iss_cyc[7] - iss_cyc[0], 7);
    chk("drain_level", {28'h0, fifo_level}, 32'h0);
    chk("drain_issue_cnt", {16'h0, issue_cnt}, 32'd12);
    chk("drain_stall_cnt", {16'h0, stall_cnt}, 32'h2);
    chk("drain_queue_empty", exp_q.size(), 0);

    // Hold in the middle of the independent pair
    push(24'h035A7D);
    push(24'h230C7E);
    chk("hold_pre_valid", {31'h0, issue_valid}, 32'h1);
    hold    = 1'b1;
    snap    = {func, rs1, rs2, rd, addr};
    snap_ic = issue_cnt;
    snap_sc = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_fields", {8'h0, func, rs1, rs2, rd, addr}, {8'h0, snap});
      chk("hold_valid", {31'h0, issue_valid}, 32'h1);
      chk("hold_issue_cnt", {16'h0, issue_cnt}, {16'h0, snap_ic});
      chk("hold_stall_cnt", {16'h0, stall_cnt}, {16'h0, snap_sc});
    end
    hold = 1'b0;
    iss_cyc.delete();
    tick();
    chk("resume_issue", iss_cyc.size(), 1);
    chk("resume_rd", {28'h0, rd}, 32'hC);
    chk("resume_issue_cnt", {16'h0, issue_cnt}, 32'd14);

    // Async reset with buffered words
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push({4'h3, 4'h1, 4'h2, 4'(4 + i), 8'(32 + i)});
    chk("areset_pre_level", {28'h0, fifo_level}, 32'h5);
    chk("areset_pre_valid", {31'h0, issue_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_level", {28'h0, fifo_level}, 32'h0);
    chk("areset_valid", {31'h0, issue_valid}, 32'h0);
    chk("areset_issue_cnt", {16'h0, issue_cnt}, 32'h0);
    chk("areset_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("areset_in_ready", {31'h0, in_ready}, 32'h1);
    exp_q.delete();
    #2;
    hold  = 1'b0;
    rst_n = 1'b1;
    iss_cyc.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("post_reset_issues", iss_cyc.size(), 0);
    chk("post_reset_valid", {31'h0, issue_valid}, 32'h0);
    chk("post_reset_issue_cnt", {16'h0, issue_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
